// File: rtl/cafeteira_uc.sv
// cafeteira_uc: control unit that sequences one coffee brew (order, water, cup, pump, heater, valve).
// Optional macro CAFETEIRA_XICARA_RETRY_EN enables timed cup re-checks; rev 1.0.
`default_nettype none

module cafeteira_uc #(
  parameter int INTERVALO_XICARA = 50000000,
  parameter int MAX_TENTATIVAS   = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       pronto_serial,
  input  logic       pronto_sensor_agua,
  input  logic       timeout_agua,
  input  logic       suficiente,
  input  logic       pronto_sensor_xicara,
  input  logic       timeout_xicara,
  input  logic       tem_xicara,
  input  logic       fim_bomba,
  input  logic       fim_ebulidor,
  input  logic       timeout_ebulidor,
  input  logic       fim_valvula,
  output logic       zera,
  output logic       medir_agua,
  output logic       verifica_xicara,
  output logic       liga_bomba,
  output logic       liga_ebulidor,
  output logic       liga_valvula,
  output logic       pronto,
  output logic       erro,
  output logic [2:0] erro_codigo,
  output logic [3:0] db_estado
);

  localparam logic [3:0] c_INICIAL         = 4'h0;
  localparam logic [3:0] c_ZERA            = 4'h1;
  localparam logic [3:0] c_ESPERA_SERIAL   = 4'h2;
  localparam logic [3:0] c_MEDE_AGUA       = 4'h3;
  localparam logic [3:0] c_ESPERA_AGUA     = 4'h4;
  localparam logic [3:0] c_VERIFICA_XICARA = 4'h5;
  localparam logic [3:0] c_ESPERA_XICARA   = 4'h6;
  localparam logic [3:0] c_AGUARDA_XICARA  = 4'h7;
  localparam logic [3:0] c_BOMBA           = 4'h8;
  localparam logic [3:0] c_EBULIDOR        = 4'h9;
  localparam logic [3:0] c_VALVULA         = 4'hA;
  localparam logic [3:0] c_FINAL           = 4'hB;
  localparam logic [3:0] c_ERRO            = 4'hF;

  localparam logic [2:0] c_COD_NENHUM       = 3'd0;
  localparam logic [2:0] c_COD_TIMEOUT_AGUA = 3'd1;
  localparam logic [2:0] c_COD_POUCA_AGUA   = 3'd2;
  localparam logic [2:0] c_COD_TIMEOUT_XIC  = 3'd3;
  localparam logic [2:0] c_COD_SEM_XICARA   = 3'd4;
  localparam logic [2:0] c_COD_TIMEOUT_EBUL = 3'd5;

  // Elaboration-time guard on the retry configuration.
  if (MAX_TENTATIVAS < 1 || MAX_TENTATIVAS > 7) begin : g_chk_tentativas
    $error("cafeteira_uc: MAX_TENTATIVAS must be within 1..7");
  end
  if (INTERVALO_XICARA < 1) begin : g_chk_intervalo
    $error("cafeteira_uc: INTERVALO_XICARA must be at least 1");
  end

  logic [3:0] estado_q, estado_d;
  logic [2:0] codigo_q, codigo_d;
  logic       viu_baixo_q, viu_baixo_d;

`ifdef CAFETEIRA_XICARA_RETRY_EN
  localparam int         c_INT_W   = (INTERVALO_XICARA > 1) ? $clog2(INTERVALO_XICARA) : 1;
  localparam logic [c_INT_W-1:0] c_INT_ULTIMO = c_INT_W'(INTERVALO_XICARA - 1);
  localparam logic [2:0] c_MAX_TENT = 3'(MAX_TENTATIVAS);

  logic [2:0]         tentativas_q, tentativas_d;
  logic [c_INT_W-1:0] intervalo_q, intervalo_d;
`endif

  always_comb begin
    estado_d    = estado_q;
    codigo_d    = codigo_q;
    viu_baixo_d = viu_baixo_q;
`ifdef CAFETEIRA_XICARA_RETRY_EN
    tentativas_d = tentativas_q;
    intervalo_d  = intervalo_q;
`endif

    case (estado_q)
      c_INICIAL: begin
        if (iniciar) estado_d = c_ZERA;
      end

      c_ZERA: begin
        codigo_d = c_COD_NENHUM;
`ifdef CAFETEIRA_XICARA_RETRY_EN
        tentativas_d = 3'd0;
`endif
        estado_d = c_ESPERA_SERIAL;
      end

      c_ESPERA_SERIAL: begin
        if (pronto_serial) estado_d = c_MEDE_AGUA;
      end

      c_MEDE_AGUA: estado_d = c_ESPERA_AGUA;

      // A timeout outranks a measurement that completes in the same cycle.
      c_ESPERA_AGUA: begin
        if (timeout_agua) begin
          estado_d = c_ERRO;
          codigo_d = c_COD_TIMEOUT_AGUA;
        end else if (pronto_sensor_agua) begin
          if (suficiente) begin
            estado_d = c_VERIFICA_XICARA;
          end else begin
            estado_d = c_ERRO;
            codigo_d = c_COD_POUCA_AGUA;
          end
        end
      end

      c_VERIFICA_XICARA: estado_d = c_ESPERA_XICARA;

      c_ESPERA_XICARA: begin
        if (timeout_xicara) begin
          estado_d = c_ERRO;
          codigo_d = c_COD_TIMEOUT_XIC;
        end else if (pronto_sensor_xicara) begin
          if (tem_xicara) begin
            estado_d = c_BOMBA;
          end else begin
`ifdef CAFETEIRA_XICARA_RETRY_EN
            if (tentativas_q < c_MAX_TENT) begin
              estado_d     = c_AGUARDA_XICARA;
              tentativas_d = tentativas_q + 3'd1;
              intervalo_d  = '0;
            end else begin
              estado_d = c_ERRO;
              codigo_d = c_COD_SEM_XICARA;
            end
`else
            estado_d = c_ERRO;
            codigo_d = c_COD_SEM_XICARA;
`endif
          end
        end
      end

`ifdef CAFETEIRA_XICARA_RETRY_EN
      c_AGUARDA_XICARA: begin
        if (intervalo_q == c_INT_ULTIMO) begin
          estado_d = c_VERIFICA_XICARA;
        end else begin
          intervalo_d = intervalo_q + 1'b1;
        end
      end
`endif

      c_BOMBA: begin
        if (fim_bomba) estado_d = c_EBULIDOR;
      end

      c_EBULIDOR: begin
        if (timeout_ebulidor) begin
          estado_d = c_ERRO;
          codigo_d = c_COD_TIMEOUT_EBUL;
        end else if (fim_ebulidor) begin
          estado_d = c_VALVULA;
        end
      end

      c_VALVULA: begin
        if (fim_valvula) estado_d = c_FINAL;
      end

      c_FINAL: estado_d = c_INICIAL;

      // Leaving ERRO needs a fresh press: a low level must be seen first.
      c_ERRO: begin
        if (!iniciar) viu_baixo_d = 1'b1;
        if (viu_baixo_q && iniciar) estado_d = c_INICIAL;
      end

      default: estado_d = c_INICIAL;
    endcase

    if (estado_d == c_ERRO && estado_q != c_ERRO) viu_baixo_d = 1'b0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q    <= c_INICIAL;
      codigo_q    <= c_COD_NENHUM;
      viu_baixo_q <= 1'b0;
    end else begin
      estado_q    <= estado_d;
      codigo_q    <= codigo_d;
      viu_baixo_q <= viu_baixo_d;
    end
  end

`ifdef CAFETEIRA_XICARA_RETRY_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tentativas_q <= 3'd0;
      intervalo_q  <= '0;
    end else begin
      tentativas_q <= tentativas_d;
      intervalo_q  <= intervalo_d;
    end
  end
`endif

  // Moore outputs: pure decode of the state register.
  always_comb begin
    zera            = 1'b0;
    medir_agua      = 1'b0;
    verifica_xicara = 1'b0;
    liga_bomba      = 1'b0;
    liga_ebulidor   = 1'b0;
    liga_valvula    = 1'b0;
    pronto          = 1'b0;
    erro            = 1'b0;
    case (estado_q)
      c_ZERA:            zera            = 1'b1;
      c_MEDE_AGUA:       medir_agua      = 1'b1;
      c_VERIFICA_XICARA: verifica_xicara = 1'b1;
      c_BOMBA:           liga_bomba      = 1'b1;
      c_EBULIDOR:        liga_ebulidor   = 1'b1;
      c_VALVULA:         liga_valvula    = 1'b1;
      c_FINAL:           pronto          = 1'b1;
      c_ERRO:            erro            = 1'b1;
      default: ;
    endcase
  end

  assign erro_codigo = codigo_q;
  assign db_estado   = estado_q;

endmodule

`default_nettype wire

// File: tb/tb_cafeteira_uc.sv
// tb_cafeteira_uc: directed per-cycle trace checks for cafeteira_uc against expected state/output traces.
`default_nettype none

module tb_cafeteira_uc;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       iniciar, pronto_serial, pronto_sensor_agua, timeout_agua, suficiente;
  logic       pronto_sensor_xicara, timeout_xicara, tem_xicara;
  logic       fim_bomba, fim_ebulidor, timeout_ebulidor, fim_valvula;
  logic       zera, medir_agua, verifica_xicara, liga_bomba, liga_ebulidor, liga_valvula;
  logic       pronto, erro;
  logic [2:0] erro_codigo;
  logic [3:0] db_estado;

  cafeteira_uc #(
    .INTERVALO_XICARA(4),
    .MAX_TENTATIVAS  (2)
  ) dut (
    .clock               (clock),
    .reset               (reset),
    .iniciar             (iniciar),
    .pronto_serial       (pronto_serial),
    .pronto_sensor_agua  (pronto_sensor_agua),
    .timeout_agua        (timeout_agua),
    .suficiente          (suficiente),
    .pronto_sensor_xicara(pronto_sensor_xicara),
    .timeout_xicara      (timeout_xicara),
    .tem_xicara          (tem_xicara),
    .fim_bomba           (fim_bomba),
    .fim_ebulidor        (fim_ebulidor),
    .timeout_ebulidor    (timeout_ebulidor),
    .fim_valvula         (fim_valvula),
    .zera                (zera),
    .medir_agua          (medir_agua),
    .verifica_xicara     (verifica_xicara),
    .liga_bomba          (liga_bomba),
    .liga_ebulidor       (liga_ebulidor),
    .liga_valvula        (liga_valvula),
    .pronto              (pronto),
    .erro                (erro),
    .erro_codigo         (erro_codigo),
    .db_estado           (db_estado)
  );

  always #5 clock = ~clock;

  // Input vector bits: {iniciar, serial, psa, toa, suf, psx, tox, tem, fb, fe, toe, fv}
  localparam logic [11:0] K_INI = 12'h800, K_SER = 12'h400, K_PSA = 12'h200, K_TOA = 12'h100;
  localparam logic [11:0] K_SUF = 12'h080, K_PSX = 12'h040, K_TOX = 12'h020, K_TEM = 12'h010;
  localparam logic [11:0] K_FB  = 12'h008, K_FE  = 12'h004, K_TOE = 12'h002, K_FV  = 12'h001;

  int         vectors = 0;
  int         miscompares = 0;
  logic [2:0] exp_code = 3'd0;
  string      scen = "reset";
  int         cnt_zera, cnt_medir, cnt_verif, cnt_bomba, cnt_ebul, cnt_valv, cnt_pronto, cnt_overlap;

  // Spec output table: which single output each state number drives.
  function automatic logic [7:0] outs_for(input logic [3:0] st);
    case (st)
      4'h1:    return 8'b1000_0000;
      4'h3:    return 8'b0100_0000;
      4'h5:    return 8'b0010_0000;
      4'h8:    return 8'b0001_0000;
      4'h9:    return 8'b0000_1000;
      4'hA:    return 8'b0000_0100;
      4'hB:    return 8'b0000_0010;
      4'hF:    return 8'b0000_0001;
      default: return 8'b0000_0000;
    endcase
  endfunction

  task automatic drive(input logic [11:0] v);
    {iniciar, pronto_serial, pronto_sensor_agua, timeout_agua, suficiente, pronto_sensor_xicara,
     timeout_xicara, tem_xicara, fim_bomba, fim_ebulidor, timeout_ebulidor, fim_valvula} = v;
  endtask

  task automatic clr_cnt();
    cnt_zera = 0; cnt_medir = 0; cnt_verif = 0; cnt_bomba = 0;
    cnt_ebul = 0; cnt_valv = 0; cnt_pronto = 0; cnt_overlap = 0;
  endtask

  // One cycle: check the state-derived outputs expected now, then apply this cycle's inputs.
  task automatic cyc(input logic [11:0] v, input logic [3:0] st);
    logic [7:0] act;
    @(negedge clock);
    act = {zera, medir_agua, verifica_xicara, liga_bomba, liga_ebulidor, liga_valvula, pronto, erro};
    vectors++;
    if (db_estado !== st || act !== outs_for(st) || erro_codigo !== exp_code) begin
      miscompares++;
      $display("FAIL %s cycle: got st=%h outs=%b code=%0d, required st=%h outs=%b code=%0d",
               scen, db_estado, act, erro_codigo, st, outs_for(st), exp_code);
    end
    cnt_zera   += int'(zera);
    cnt_medir  += int'(medir_agua);
    cnt_verif  += int'(verifica_xicara);
    cnt_bomba  += int'(liga_bomba);
    cnt_ebul   += int'(liga_ebulidor);
    cnt_valv   += int'(liga_valvula);
    cnt_pronto += int'(pronto);
    if (int'(liga_bomba) + int'(liga_ebulidor) + int'(liga_valvula) > 1) cnt_overlap++;
    drive(v);
  endtask

  task automatic chk(input string name, input int act, input int req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // From INICIAL through ZERA to the first ESPERA_AGUA cycle (inputs of that cycle not yet applied).
  task automatic to_agua();
    cyc(K_INI, 4'h0);
    cyc(12'h0, 4'h1);
    exp_code = 3'd0;
    cyc(K_SER, 4'h2);
    cyc(12'h0, 4'h3);
  endtask

  task automatic do_reset(input string name);
    @(negedge clock);
    drive(12'h0);
    #2 reset = 1'b0;
    #1;
    exp_code = 3'd0;
    chk({name, " st"}, int'(db_estado), 0);
    chk({name, " liga"}, int'({liga_bomba, liga_ebulidor, liga_valvula}), 0);
    chk({name, " code"}, int'(erro_codigo), 0);
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    drive(12'h0);
    clr_cnt();
    repeat (3) @(negedge clock);
    chk("reset st", int'(db_estado), 0);
    chk("reset outs", int'({zera, medir_agua, verifica_xicara, liga_bomba, liga_ebulidor,
                           liga_valvula, pronto, erro}), 0);
    chk("reset code", int'(erro_codigo), 0);
    reset = 1'b1;

    // Nominal brew, with stray events in states that must ignore them.
    scen = "nominal";
    clr_cnt();
    cyc(K_SER | K_FB, 4'h0);
    cyc(K_INI, 4'h0);
    cyc(12'h0, 4'h1);
    cyc(K_FB | K_FV, 4'h2);
    cyc(12'h0, 4'h2);
    cyc(K_SER, 4'h2);
    cyc(12'h0, 4'h3);
    cyc(12'h0, 4'h4);
    cyc(K_PSA | K_SUF, 4'h4);
    cyc(12'h0, 4'h5);
    cyc(K_PSX | K_TEM, 4'h6);
    for (int i = 0; i < 4; i++) cyc(12'h0, 4'h8);
    cyc(K_FB, 4'h8);
    for (int i = 0; i < 4; i++) cyc(12'h0, 4'h9);
    cyc(K_FE, 4'h9);
    for (int i = 0; i < 4; i++) cyc(12'h0, 4'hA);
    cyc(K_FV, 4'hA);
    cyc(K_INI, 4'hB);
    chk("nominal zera pulses", cnt_zera, 1);
    chk("nominal medir pulses", cnt_medir, 1);
    chk("nominal verif pulses", cnt_verif, 1);
    chk("nominal pronto pulses", cnt_pronto, 1);
    chk("nominal bomba cycles", cnt_bomba, 5);
    chk("nominal ebulidor cycles", cnt_ebul, 5);
    chk("nominal valvula cycles", cnt_valv, 5);
    chk("nominal liga overlap", cnt_overlap, 0);

    // iniciar still high after FINAL: the next brew starts right away; water is low.
    scen = "low water";
    clr_cnt();
    to_agua();
    cyc(K_PSA, 4'h4);
    exp_code = 3'd2;
    cyc(K_INI, 4'hF);
    cyc(K_INI, 4'hF);
    cyc(12'h0, 4'hF);
    cyc(K_INI, 4'hF);
    chk("low water liga cycles", cnt_bomba + cnt_ebul + cnt_valv, 0);
    chk("low water code held", int'(erro_codigo), 2);
    cyc(K_INI, 4'h0);
    cyc(12'h0, 4'h1);
    exp_code = 3'd0;
    cyc(12'h0, 4'h2);
    chk("low water code cleared", int'(erro_codigo), 0);

    // Heater timeout and finish in the same cycle.
    scen = "heater simultaneous";
    clr_cnt();
    cyc(K_SER, 4'h2);
    cyc(12'h0, 4'h3);
    cyc(K_PSA | K_SUF, 4'h4);
    cyc(12'h0, 4'h5);
    cyc(K_PSX | K_TEM, 4'h6);
    cyc(K_FB, 4'h8);
    cyc(12'h0, 4'h9);
    cyc(K_FE | K_TOE, 4'h9);
    exp_code = 3'd5;
    cyc(12'h0, 4'hF);
    chk("heater liga_ebulidor after", int'(liga_ebulidor), 0);
    cyc(K_FV, 4'hF);
    chk("heater valvula cycles", cnt_valv, 0);
    chk("heater code", int'(erro_codigo), 5);
    cyc(K_INI, 4'hF);

    // Water timeout wins over a simultaneous sufficient reading.
    scen = "water timeout";
    to_agua();
    cyc(K_TOA | K_PSA | K_SUF, 4'h4);
    exp_code = 3'd1;
    cyc(12'h0, 4'hF);
    cyc(K_INI, 4'hF);

    scen = "cup timeout";
    to_agua();
    cyc(K_PSA | K_SUF, 4'h4);
    cyc(12'h0, 4'h5);
    cyc(K_TOX, 4'h6);
    exp_code = 3'd3;
    cyc(12'h0, 4'hF);
    cyc(K_INI, 4'hF);

`ifdef CAFETEIRA_XICARA_RETRY_EN
    scen = "cup retry ok";
    clr_cnt();
    to_agua();
    cyc(K_PSA | K_SUF, 4'h4);
    for (int r = 0; r < 2; r++) begin
      cyc(12'h0, 4'h5);
      cyc(K_PSX, 4'h6);
      for (int i = 0; i < 4; i++) cyc(12'h0, 4'h7);
    end
    cyc(12'h0, 4'h5);
    cyc(K_PSX | K_TEM, 4'h6);
    cyc(K_FB, 4'h8);
    chk("retry verif pulses", cnt_verif, 3);
    cyc(K_FE, 4'h9);
    cyc(K_FV, 4'hA);
    cyc(K_INI, 4'hB);

    scen = "cup retry exhausted";
    clr_cnt();
    to_agua();
    cyc(K_PSA | K_SUF, 4'h4);
    for (int r = 0; r < 2; r++) begin
      cyc(12'h0, 4'h5);
      cyc(K_PSX, 4'h6);
      for (int i = 0; i < 4; i++) cyc(12'h0, 4'h7);
    end
    cyc(12'h0, 4'h5);
    cyc(K_PSX, 4'h6);
    exp_code = 3'd4;
    cyc(12'h0, 4'hF);
    chk("retry exhausted verif pulses", cnt_verif, 3);
    chk("retry exhausted code", int'(erro_codigo), 4);
`else
    scen = "cup absent";
    clr_cnt();
    to_agua();
    cyc(K_PSA | K_SUF, 4'h4);
    cyc(12'h0, 4'h5);
    cyc(K_PSX, 4'h6);
    exp_code = 3'd4;
    cyc(12'h0, 4'hF);
    chk("cup absent verif pulses", cnt_verif, 1);
    chk("cup absent code", int'(erro_codigo), 4);
`endif

    // Reset while in ERRO clears the error code.
    scen = "reset in erro";
    do_reset("reset in erro");
    cyc(12'h0, 4'h0);

    // Reset while pumping drops the pump at once.
    scen = "reset mid-pump";
    to_agua();
    cyc(K_PSA | K_SUF, 4'h4);
    cyc(12'h0, 4'h5);
    cyc(K_PSX | K_TEM, 4'h6);
    cyc(12'h0, 4'h8);
    cyc(12'h0, 4'h8);
    #1 chk("pump on before reset", int'(liga_bomba), 1);
    do_reset("reset mid-pump");
    cyc(12'h0, 4'h0);
    cyc(12'h0, 4'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/cafeteira_uc.md
Name: cafeteira_uc

Overview:
Control unit (UC) for the coffee maker; directly consumes every status output of the coffee-maker datapath and drives its zero/measure/enable inputs. Sequences one brew: wait for order over serial, check water level, check cup, pump, boil, open valve. Reports completion, error code and a debug state number.

Parameters:
INTERVALO_XICARA, 50000000, cycles waited between cup re-checks (retry feature only)
MAX_TENTATIVAS, 3, extra cup checks after the first failed one (retry feature only; 1..7)

Ports:
clock  input  1  system clock; all state changes on rising edge
reset  input  1  asynchronous, active-low reset
iniciar  input  1  start/acknowledge level, sampled each cycle
pronto_serial  input  1  order received from ESP (brew mode latched in datapath)
pronto_sensor_agua  input  1  water measurement complete
timeout_agua  input  1  water sensor timed out
suficiente  input  1  water level sufficient for selected mode; valid with pronto_sensor_agua
pronto_sensor_xicara  input  1  cup measurement complete
timeout_xicara  input  1  cup sensor timed out
tem_xicara  input  1  cup present; valid with pronto_sensor_xicara
fim_bomba  input  1  pump dose finished
fim_ebulidor  input  1  target temperature reached
timeout_ebulidor  input  1  heater timed out
fim_valvula  input  1  valve dispensing finished
zera  output  1  one-cycle clear pulse, fanned out at top level to all six datapath zera_* inputs
medir_agua  output  1  one-cycle water measurement request
verifica_xicara  output  1  one-cycle cup measurement request
liga_bomba  output  1  pump enable level
liga_ebulidor  output  1  heater enable level
liga_valvula  output  1  valve enable level
pronto  output  1  one-cycle brew-complete pulse
erro  output  1  high while in ERRO
erro_codigo  output  3  last error code; 0 = none
db_estado  output  4  current state encoding

Behaviour:
- Moore FSM; all outputs decoded from the state register only; erro_codigo and the retry/interval counters are registers. Reset (async, low): state INICIAL, all outputs 0, erro_codigo 0, counters 0; liga_* drop the instant reset asserts.
- States (db_estado): INICIAL 0, ZERA 1, ESPERA_SERIAL 2, MEDE_AGUA 3, ESPERA_AGUA 4, VERIFICA_XICARA 5, ESPERA_XICARA 6, AGUARDA_XICARA 7, BOMBA 8, EBULIDOR 9, VALVULA A, FINAL B, ERRO F.
- INICIAL -> ZERA when iniciar=1. ZERA: zera=1 for exactly one cycle, erro_codigo<=0, retry counter<=0 -> ESPERA_SERIAL.
- ESPERA_SERIAL -> MEDE_AGUA on pronto_serial. MEDE_AGUA: medir_agua=1 one cycle -> ESPERA_AGUA.
- ESPERA_AGUA: timeout_agua -> ERRO code 1 (timeout wins if same cycle as pronto); pronto_sensor_agua & !suficiente -> ERRO code 2; pronto_sensor_agua & suficiente -> VERIFICA_XICARA.
- VERIFICA_XICARA: verifica_xicara=1 one cycle -> ESPERA_XICARA. ESPERA_XICARA: timeout_xicara -> ERRO code 3; pronto & tem_xicara -> BOMBA; pronto & !tem_xicara -> ERRO code 4 (see optional feature).
- BOMBA: liga_bomba=1 until fim_bomba -> EBULIDOR. EBULIDOR: liga_ebulidor=1; timeout_ebulidor -> ERRO code 5 (wins over fim_ebulidor); fim_ebulidor -> VALVULA. VALVULA: liga_valvula=1 until fim_valvula -> FINAL.
- At most one liga_* high in any cycle; every liga_* drops in the same edge the state leaves.
- FINAL: pronto=1 one cycle -> INICIAL; if iniciar still 1, the next brew starts on the following cycle.
- ERRO: erro=1, all liga_* 0; holds until iniciar=0 seen then iniciar=1 (fresh press) -> INICIAL. erro_codigo holds its value until the next ZERA.
- Input events in a state that does not consume them are ignored.

Optional Feature:
CAFETEIRA_XICARA_RETRY_EN. Defined: in ESPERA_XICARA, pronto & !tem_xicara with retry count < MAX_TENTATIVAS -> AGUARDA_XICARA, count+1; AGUARDA_XICARA waits exactly INTERVALO_XICARA cycles -> VERIFICA_XICARA; count = MAX_TENTATIVAS -> ERRO code 4. Undefined: AGUARDA_XICARA and its counters are absent; the first absent cup -> ERRO code 4; db_estado never shows 7.

Test Plan:
Nominal: iniciar=1, pronto_serial, suficiente=1, tem_xicara=1, fim_bomba/fim_ebulidor/fim_valvula after 5 cycles each -> db_estado 0,1,2,3,4,5,6,8,9,A,B,0; zera, medir_agua, verifica_xicara, pronto each exactly 1 cycle; liga_* each high exactly 5 cycles, never overlapping.
Low water: pronto_sensor_agua=1 & suficiente=0 -> ERRO, erro=1, erro_codigo=2, no liga_*; iniciar 0->1 -> INICIAL; next ZERA clears erro_codigo to 0.
Simultaneous: timeout_ebulidor=1 and fim_ebulidor=1 on same cycle -> erro_codigo=5, liga_ebulidor low next cycle, liga_valvula never asserted.
Retry (macro on, INTERVALO_XICARA=4, MAX_TENTATIVAS=2): tem_xicara=0 twice then 1 -> two 4-cycle waits in state 7, three verifica_xicara pulses, then BOMBA; with 3 failures -> erro_codigo=4.
Reset mid-pump: reset low while liga_bomba=1 -> liga_bomba 0 immediately, db_estado=0, erro_codigo=0 on release.
Macro off: first tem_xicara=0 -> erro_codigo=4 directly, exactly one verifica_xicara pulse.
